// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and helpers for the 5-stage MIPS pipeline.
//                XLEN        - datapath width
//                INSTR_BYTES - size of one instruction word in bytes
//                NOP_WORD    - encoding of sll $0,$0,0
//                PC_RESET    - default program-counter reset value
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int               XLEN        = 32;
    localparam int               INSTR_BYTES = 4;
    localparam logic [XLEN-1:0]  NOP_WORD    = 32'h0000_0000;
    localparam logic [XLEN-1:0]  PC_RESET    = 32'h0000_0000;

    // Instruction addresses are word aligned; drop the byte-offset bits.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/add_32.sv
`default_nettype none
// ============================================================================
//  Module      : add_32
//  Description : 32-bit modulo-2^32 adder, no carry-out.
//  Ports       : a   (in,  32) - first operand
//                b   (in,  32) - second operand
//                sum (out, 32) - a + b, truncated to 32 bits
//  Revision    : 1.0 - initial release
// ============================================================================
module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule : add_32
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage
//  Description : Instruction-fetch stage. Holds the PC, drives the
//                instruction-memory address, computes PC+4, selects the next
//                PC (redirect > stall > sequential) and loads the IF/ID
//                pipeline register.
//  Ports       : clk                 (in,   1) rising-edge clock
//                rst                 (in,   1) synchronous active-high reset
//                stall               (in,   1) hold PC and IF/ID
//                redirect            (in,   1) flush IF/ID, load redirect_pc
//                redirect_pc         (in,  32) redirect target
//                imem_addr           (out, 32) instruction-memory address
//                imem_rdata          (in,  32) instruction word at imem_addr
//                if_id_valid         (out,  1) IF/ID holds a real instruction
//                if_id_instr         (out, 32) IF/ID instruction
//                if_id_pc4           (out, 32) IF/ID PC+4
//                redirect_misaligned (out,  1) last redirect target unaligned
//                fetch_cnt           (out, 32) instructions loaded since reset
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = PC_RESET,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        redirect_misaligned,
    output logic [31:0] fetch_cnt
);

    localparam logic [XLEN-1:0] c_instr_bytes = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc4;
    logic            r_misaligned;
    logic [XLEN-1:0] r_fetch_cnt;

    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_pc_next;
    logic            w_load;

    add_32 u_pc_adder (
        .a   (r_pc),
        .b   (c_instr_bytes),
        .sum (w_pc4)
    );

    // Redirect outranks stall: a taken branch/jump in EX must not be lost
    // just because the hazard unit is holding the front end.
    always_comb begin
        w_pc_next = w_pc4;
        if (redirect) begin
            w_pc_next = word_align(redirect_pc);
        end else if (stall) begin
            w_pc_next = r_pc;
        end
    end

    assign w_load = !redirect && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_pc4        <= '0;
            r_misaligned <= 1'b0;
            r_fetch_cnt  <= '0;
        end else begin
            r_pc         <= w_pc_next;
            r_misaligned <= redirect && (redirect_pc[1:0] != 2'b00);
            if (redirect) begin
                r_valid <= 1'b0;
                r_instr <= NOP_INSTR;
                r_pc4   <= '0;
            end else if (w_load) begin
                r_valid     <= 1'b1;
                r_instr     <= imem_rdata;
                r_pc4       <= w_pc4;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign imem_addr           = r_pc;
    assign if_id_valid         = r_valid;
    assign if_id_instr         = r_instr;
    assign if_id_pc4           = r_pc4;
    assign redirect_misaligned = r_misaligned;
    assign fetch_cnt           = r_fetch_cnt;

endmodule : if_fetch_stage
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_stage
//  Description : Directed, table-driven bench for if_fetch_stage. The
//                instruction memory returns its own address as data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        redirect_misaligned;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int seen_80  = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .redirect            (redirect),
        .redirect_pc         (redirect_pc),
        .imem_addr           (imem_addr),
        .imem_rdata          (imem_rdata),
        .if_id_valid         (if_id_valid),
        .if_id_instr         (if_id_instr),
        .if_id_pc4           (if_id_pc4),
        .redirect_misaligned (redirect_misaligned),
        .fetch_cnt           (fetch_cnt)
    );

    // Address 0x80 must never be presented to memory or decode after the
    // reset-during-redirect case.
    always @(negedge clk) begin
        if (!rst && (imem_addr == 32'h80 || (if_id_valid && if_id_instr == 32'h80)))
            seen_80 = seen_80 + 1;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic s, input logic d,
                                input logic [31:0] rp, input logic [31:0] a,
                                input logic v, input logic [31:0] ins,
                                input logic [31:0] p4, input logic m,
                                input logic [31:0] c);
        vec_t t;
        t.rst = r; t.stall = s; t.redirect = d; t.rpc = rp;
        t.e_addr = a; t.e_valid = v; t.e_instr = ins; t.e_pc4 = p4;
        t.e_mis = m; t.e_cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " imem_addr"},   imem_addr,                  v.e_addr);
        chk({tag, " valid"},       {31'b0, if_id_valid},        {31'b0, v.e_valid});
        chk({tag, " instr"},       if_id_instr,                v.e_instr);
        chk({tag, " pc4"},         if_id_pc4,                  v.e_pc4);
        chk({tag, " misaligned"},  {31'b0, redirect_misaligned}, {31'b0, v.e_mis});
        chk({tag, " fetch_cnt"},   fetch_cnt,                  v.e_cnt);
    endtask

    initial begin
        //             rst stl red rpc            addr          v  instr         pc4           m  cnt
        vecs[0]  = mk(1, 0, 0, 32'h0,          32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[1]  = mk(1, 0, 0, 32'h0,          32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[2]  = mk(0, 0, 0, 32'h0,          32'h4,        1, 32'h0,        32'h4,        0, 1);
        vecs[3]  = mk(0, 0, 0, 32'h0,          32'h8,        1, 32'h4,        32'h8,        0, 2);
        vecs[4]  = mk(0, 0, 0, 32'h0,          32'hC,        1, 32'h8,        32'hC,        0, 3);
        vecs[5]  = mk(0, 0, 0, 32'h0,          32'h10,       1, 32'hC,        32'h10,       0, 4);
        vecs[6]  = mk(0, 1, 0, 32'h0,          32'h10,       1, 32'hC,        32'h10,       0, 4);
        vecs[7]  = mk(0, 1, 0, 32'h0,          32'h10,       1, 32'hC,        32'h10,       0, 4);
        vecs[8]  = mk(0, 1, 0, 32'h0,          32'h10,       1, 32'hC,        32'h10,       0, 4);
        vecs[9]  = mk(0, 0, 0, 32'h0,          32'h14,       1, 32'h10,       32'h14,       0, 5);
        vecs[10] = mk(0, 1, 1, 32'h100,        32'h100,      0, 32'h0,        32'h0,        0, 5);
        vecs[11] = mk(0, 0, 0, 32'h0,          32'h104,      1, 32'h100,      32'h104,      0, 6);
        vecs[12] = mk(0, 0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 0, 32'h0,       32'h0,        0, 6);
        vecs[13] = mk(0, 0, 0, 32'h0,          32'h0,        1, 32'hFFFF_FFFC, 32'h0,       0, 7);
        vecs[14] = mk(0, 0, 0, 32'h0,          32'h4,        1, 32'h0,        32'h4,        0, 8);
        vecs[15] = mk(0, 0, 1, 32'h203,        32'h200,      0, 32'h0,        32'h0,        1, 8);
        vecs[16] = mk(0, 0, 0, 32'h0,          32'h204,      1, 32'h200,      32'h204,      0, 9);
        vecs[17] = mk(1, 0, 1, 32'h80,         32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[18] = mk(0, 0, 0, 32'h0,          32'h4,        1, 32'h0,        32'h4,        0, 1);
        vecs[19] = mk(1, 1, 0, 32'h0,          32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[20] = mk(0, 0, 0, 32'h0,          32'h4,        1, 32'h0,        32'h4,        0, 1);

        for (int i = 0; i < NVEC; i++) begin
            rst         = vecs[i].rst;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Long stall: state after vec20 is pc=4, IF/ID = {0, pc4 4}, cnt 1.
        rst = 1'b0; redirect = 1'b0; stall = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("hold%0d", k),
                      mk(0, 1, 0, 32'h0, 32'h4, 1, 32'h0, 32'h4, 0, 1));
        end

        // Misaligned redirect while stalled: pulse lasts exactly one cycle.
        redirect = 1'b1; redirect_pc = 32'h0000_0402;
        @(posedge clk);
        #1;
        check_all("misal_stall", mk(0, 1, 1, 32'h0, 32'h400, 0, 32'h0, 32'h0, 1, 1));
        redirect = 1'b0;
        @(posedge clk);
        #1;
        check_all("misal_hold", mk(0, 1, 0, 32'h0, 32'h400, 0, 32'h0, 32'h0, 0, 1));
        stall = 1'b0;
        @(posedge clk);
        #1;
        check_all("misal_resume", mk(0, 0, 0, 32'h0, 32'h404, 1, 32'h400, 32'h404, 0, 2));

        chk("never_fetched_0x80", seen_80, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_if_fetch_stage
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the program counter and drives the instruction-memory address.
- Computes PC+4 through an instance of the team's 32-bit adder, selects the next PC, and loads the IF/ID pipeline register consumed by decode.
- Handles hazard-unit stall and EX-stage redirect (branch/jump/jr) with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on reset and flush (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect  in  1  EX stage: branch taken or jump; flush IF/ID and load redirect_pc
- redirect_pc  in  32  redirect target address
- imem_addr  out  32  instruction-memory address (combinational = pc_q)
- imem_rdata  in  32  instruction word (combinational read of imem_addr)
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  32  IF/ID instruction
- if_id_pc4  out  32  IF/ID PC+4 (used for branch target and jal link)
- redirect_misaligned  out  1  one-cycle pulse: last accepted redirect_pc had bits [1:0] != 0
- fetch_cnt  out  32  number of instructions loaded into IF/ID since reset

Behaviour:
- Reset is synchronous and overrides all other inputs. On the edge with rst=1:
  - pc_q=RESET_PC
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc4=0
  - redirect_misaligned=0, fetch_cnt=0
- Reset asserted mid-stall or mid-redirect: reset wins; the first fetch after rst drops is RESET_PC.
- pc4 = pc_q + 32'd4 via the adder. Result is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no carry-out or flag.
- Next-PC priority on each edge (rst=0):
  1. redirect=1: pc_q <= {redirect_pc[31:2],2'b00}. Redirect also wins when stall=1.
  2. stall=1: pc_q held.
  3. Otherwise: pc_q <= pc4.
- IF/ID register, same priority:
  - redirect=1: valid<=0, instr<=NOP_INSTR, pc4<=0 (flush, even if stall=1).
  - stall=1: all IF/ID fields held.
  - Otherwise: instr<=imem_rdata, pc4<=pc4, valid<=1.
- Latency: the word at address A appears on if_id_instr exactly one cycle after pc_q==A with no stall.
- After a redirect, one bubble (valid=0) is visible before the target instruction appears.
- redirect_misaligned is registered: 1 for the cycle after an edge where redirect=1 and redirect_pc[1:0]!=0, otherwise 0. pc_q[1:0] is always 00.
- fetch_cnt increments by 1 on every edge that loads IF/ID with valid<=1. It wraps 32'hFFFF_FFFF -> 0. It does not increment on stall, flush or reset.
- No internal state machine beyond the registers above.
- Holding stall=1 for any number of cycles is legal; outputs stay frozen.

Decomposition:
- Shared package mips_pkg:
  - XLEN=32
  - INSTR_BYTES=4
  - NOP_WORD=32'h0000_0000
  - PC_RESET=32'h0000_0000
- Sub-module: one instance of the existing 32-bit adder (add_32) for PC+4, with b tied to INSTR_BYTES.
- Next-PC mux, PC register, IF/ID register and counter are inline RTL.

Test Plan:
- Reset then free-run, imem returning {addr}: after rst drops, if_id_instr = 0x0, 0x4, 0x8 on consecutive cycles; if_id_pc4 = 0x4, 0x8, 0xC; fetch_cnt = 1, 2, 3.
- Stall for 3 cycles with pc_q=0x10: imem_addr stays 0x10 and IF/ID holds instr 0xC / pc4 0x10 for 3 cycles; fetch_cnt is unchanged; fetch resumes at 0x10.
- Redirect to 0x100 with stall=1 on the same edge: next cycle pc_q=0x100 and if_id_valid=0 with NOP; following cycle if_id_instr=0x100, if_id_pc4=0x104.
- Wrap: force redirect_pc=0xFFFF_FFFC: next fetch has pc4=0x0000_0000 and imem_addr becomes 0x0.
- Misaligned redirect_pc=0x203: pc_q=0x200; redirect_misaligned=1 for exactly one cycle.
- Assert rst during a redirect cycle (redirect_pc=0x80): pc_q=RESET_PC, if_id_valid=0 and fetch_cnt=0 next cycle; 0x80 is never fetched.
